// File: rtl/csr_ssm_irq.sv
// csr_ssm_irq: machine-mode CSR file and trap controller with prioritised interrupts,
// vectored mtvec and 64-bit mcycle/minstret counters.
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_external/software/timer_interrupt level-sensitive MEI/MSI/MTI
//   i_local_interrupt                   NUM_LOCAL_IRQ level-sensitive lines (mip/mie bits 16+k)
//   i_ce, i_is_*                        writeback-stage valid and decoded trap/return events
//   i_csr_en, i_funct3, i_csr_index     CSR instruction, op and address
//   i_rs1, i_imm, i_pc, i_y             operand, zimm, instruction PC, faulting address
//   o_csr_out                           combinational read of i_csr_index (pre-write value)
//   o_trap_address, o_return_address    trap vector and mepc for the PC mux
//   o_go_to_trap_q, o_return_from_trap_q one-cycle registered trap-entry / MRET pulses
module csr_ssm_irq #(
    parameter logic [31:0] TRAP_ADDRESS = 32'h0000_0000,
    parameter int NUM_LOCAL_IRQ = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_external_interrupt,
    input  logic                     i_software_interrupt,
    input  logic                     i_timer_interrupt,
    input  logic [NUM_LOCAL_IRQ-1:0] i_local_interrupt,
    input  logic                     i_ce,
    input  logic                     i_is_inst_illegal,
    input  logic                     i_is_ecall,
    input  logic                     i_is_ebreak,
    input  logic                     i_is_mret,
    input  logic                     i_is_inst_addr_misaligned,
    input  logic                     i_is_load_addr_misaligned,
    input  logic                     i_is_store_addr_misaligned,
    input  logic                     i_csr_en,
    input  logic [2:0]               i_funct3,
    input  logic [11:0]              i_csr_index,
    input  logic [31:0]              i_rs1,
    input  logic [31:0]              i_imm,
    input  logic [31:0]              i_pc,
    input  logic [31:0]              i_y,
    output logic [31:0]              o_csr_out,
    output logic [31:0]              o_trap_address,
    output logic [31:0]              o_return_address,
    output logic                     o_go_to_trap_q,
    output logic                     o_return_from_trap_q
);
    // MSIE/MTIE/MEIE plus one bit per local line starting at bit 16
    localparam logic [31:0] IRQ_MASK = 32'h0000_0888 | (((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16);

    logic        mstatus_mie, mstatus_mpie;
    logic [31:0] mie_q, mip_q, mscratch, mcause, mtval;
    logic [29:0] mtvec_base, mepc_q;
    logic        mtvec_mode;
    logic [63:0] mcycle, minstret;
    logic [31:0] irq_in, pending, src, wdata, trap_val;
    logic [4:0]  int_code, exc_code, trap_code;
    logic        flush, valid, take_int, take_exc, take_trap, do_mret, we_op, csr_we;
    logic        unused_imm;

    assign unused_imm = ^i_imm[31:5];

    assign irq_in = (32'(i_local_interrupt) << 16)
                  | {20'b0, i_external_interrupt, 3'b0, i_timer_interrupt, 3'b0, i_software_interrupt, 3'b0};

    // Both pulses mark the cycle in which the pipeline is being redirected
    assign flush     = o_go_to_trap_q | o_return_from_trap_q;
    assign valid     = i_ce & ~flush;
    assign pending   = mip_q & mie_q;
    assign take_int  = valid & mstatus_mie & |pending;
    assign take_exc  = valid & (i_is_inst_addr_misaligned | i_is_inst_illegal | i_is_ebreak | i_is_ecall
                              | i_is_load_addr_misaligned | i_is_store_addr_misaligned);
    assign take_trap = take_int | take_exc;
    assign do_mret   = valid & i_is_mret & ~take_trap;

    // Walk local lines from high to low so the lowest index wins, then the fixed core ones on top
    always_comb begin
        int_code = 5'd0;
        for (int k = NUM_LOCAL_IRQ - 1; k >= 0; k--)
            if (pending[16 + k]) int_code = 5'(16 + k);
        if (pending[7])  int_code = 5'd7;
        if (pending[3])  int_code = 5'd3;
        if (pending[11]) int_code = 5'd11;
    end

    assign exc_code  = i_is_inst_addr_misaligned ? 5'd0 : i_is_inst_illegal ? 5'd2 : i_is_ebreak ? 5'd3 :
                       i_is_ecall ? 5'd11 : i_is_load_addr_misaligned ? 5'd4 : 5'd6;
    assign trap_code = take_int ? int_code : exc_code;
    assign trap_val  = take_int ? 32'b0 : i_is_inst_addr_misaligned ? i_y : i_is_inst_illegal ? 32'b0 :
                       i_is_ebreak ? i_pc : i_is_ecall ? 32'b0 : i_y;

    always_comb begin
        case (i_csr_index)
            12'h300: o_csr_out = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            12'h304: o_csr_out = mie_q;
            12'h344: o_csr_out = mip_q;
            12'h305: o_csr_out = {mtvec_base, 1'b0, mtvec_mode};
            12'h340: o_csr_out = mscratch;
            12'h341: o_csr_out = {mepc_q, 2'b00};
            12'h342: o_csr_out = mcause;
            12'h343: o_csr_out = mtval;
            12'hB00: o_csr_out = mcycle[31:0];
            12'hB80: o_csr_out = mcycle[63:32];
            12'hB02: o_csr_out = minstret[31:0];
            12'hB82: o_csr_out = minstret[63:32];
            default: o_csr_out = 32'b0;
        endcase
    end

    assign src    = i_funct3[2] ? {27'b0, i_imm[4:0]} : i_rs1;
    assign wdata  = (i_funct3[1:0] == 2'b10) ? (o_csr_out | src) :
                    (i_funct3[1:0] == 2'b11) ? (o_csr_out & ~src) : src;
    // Set/clear with a zero source is a pure read
    assign we_op  = (i_funct3[1:0] == 2'b01) | (i_funct3[1] & |src);
    assign csr_we = i_ce & i_csr_en & ~take_trap & ~flush & we_op;

    assign o_return_address = {mepc_q, 2'b00};
    assign o_trap_address   = {mtvec_base, 2'b00}
                            + ((mtvec_mode & mcause[31]) ? {25'b0, mcause[4:0], 2'b00} : 32'b0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mstatus_mie          <= 1'b0;
            mstatus_mpie         <= 1'b0;
            mie_q                <= 32'b0;
            mip_q                <= 32'b0;
            mtvec_base           <= TRAP_ADDRESS[31:2];
            mtvec_mode           <= 1'b0;
            mscratch             <= 32'b0;
            mepc_q               <= 30'b0;
            mcause               <= 32'b0;
            mtval                <= 32'b0;
            mcycle               <= 64'b0;
            minstret             <= 64'b0;
            o_go_to_trap_q       <= 1'b0;
            o_return_from_trap_q <= 1'b0;
        end else begin
            mip_q <= irq_in;
            mcycle <= (csr_we && i_csr_index == 12'hB00) ? {mcycle[63:32], wdata} :
                      (csr_we && i_csr_index == 12'hB80) ? {wdata, mcycle[31:0]} : mcycle + 64'd1;
            minstret <= (csr_we && i_csr_index == 12'hB02) ? {minstret[63:32], wdata} :
                        (csr_we && i_csr_index == 12'hB82) ? {wdata, minstret[31:0]} :
                        minstret + {63'b0, valid & ~take_trap};
            if (csr_we) begin
                case (i_csr_index)
                    12'h300: begin
                        mstatus_mie  <= wdata[3];
                        mstatus_mpie <= wdata[7];
                    end
                    12'h304: mie_q <= wdata & IRQ_MASK;
                    12'h305: begin
                        mtvec_base <= wdata[31:2];
                        if (!wdata[1]) mtvec_mode <= wdata[0];
                    end
                    12'h340: mscratch <= wdata;
                    12'h341: mepc_q   <= wdata[31:2];
                    12'h342: mcause   <= wdata;
                    12'h343: mtval    <= wdata;
                    default: ;
                endcase
            end
            // MRET follows the CSR write so its MIE/MPIE update wins if both occur
            if (take_trap) begin
                mepc_q       <= i_pc[31:2];
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
                mcause       <= {take_int, 26'b0, trap_code};
                mtval        <= trap_val;
            end else if (do_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
            o_go_to_trap_q       <= take_trap;
            o_return_from_trap_q <= do_mret;
        end
    end
endmodule

// File: tb/tb_csr_ssm_irq.sv
// tb_csr_ssm_irq: directed and randomized checks of csr_ssm_irq against a behavioural model.
module tb_csr_ssm_irq;
    localparam logic [31:0] TRAP = 32'h0000_0203;
    localparam int NL = 4;
    localparam logic [31:0] MASK = 32'h000F_0888;

    logic        i_clk = 1'b0, i_rst_n = 1'b0;
    logic        i_external_interrupt = 0, i_software_interrupt = 0, i_timer_interrupt = 0;
    logic [NL-1:0] i_local_interrupt = '0;
    logic        i_ce, i_is_inst_illegal, i_is_ecall, i_is_ebreak, i_is_mret;
    logic        i_is_inst_addr_misaligned, i_is_load_addr_misaligned, i_is_store_addr_misaligned;
    logic        i_csr_en;
    logic [2:0]  i_funct3;
    logic [11:0] i_csr_index = 12'h0;
    logic [31:0] i_rs1, i_imm, i_pc = 0, i_y = 0;
    logic [31:0] o_csr_out, o_trap_address, o_return_address;
    logic        o_go_to_trap_q, o_return_from_trap_q;

    csr_ssm_irq #(.TRAP_ADDRESS(TRAP), .NUM_LOCAL_IRQ(NL)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_external_interrupt(i_external_interrupt), .i_software_interrupt(i_software_interrupt),
        .i_timer_interrupt(i_timer_interrupt), .i_local_interrupt(i_local_interrupt),
        .i_ce(i_ce), .i_is_inst_illegal(i_is_inst_illegal), .i_is_ecall(i_is_ecall),
        .i_is_ebreak(i_is_ebreak), .i_is_mret(i_is_mret),
        .i_is_inst_addr_misaligned(i_is_inst_addr_misaligned),
        .i_is_load_addr_misaligned(i_is_load_addr_misaligned),
        .i_is_store_addr_misaligned(i_is_store_addr_misaligned),
        .i_csr_en(i_csr_en), .i_funct3(i_funct3), .i_csr_index(i_csr_index),
        .i_rs1(i_rs1), .i_imm(i_imm), .i_pc(i_pc), .i_y(i_y),
        .o_csr_out(o_csr_out), .o_trap_address(o_trap_address), .o_return_address(o_return_address),
        .o_go_to_trap_q(o_go_to_trap_q), .o_return_from_trap_q(o_return_from_trap_q)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0, checks = 0;
    bit run = 0;

    logic [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;
    logic        m_go, m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [11:0] idx);
        case (idx)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h344: return m_mip;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mtrap_addr();
        logic [31:0] base, off;
        base = {m_mtvec[31:2], 2'b00};
        off = (m_mtvec[1:0] == 2'd1 && m_mcause[31]) ? 32'(m_mcause[4:0]) * 32'd4 : 32'd0;
        return base + off;
    endfunction

    task automatic model_reset();
        m_mstatus = 32'h1800; m_mtvec = {TRAP[31:2], 2'b00};
        m_mie = 0; m_mip = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cycle = 0; m_instret = 0; m_go = 0; m_ret = 0;
    endtask

    // One clock edge of the architectural rules, evaluated on the inputs held across that edge
    task automatic model_step();
        logic flush, valid, take_int, take_exc, take, we;
        logic [31:0] pend, src, old, nv, tval, old_st;
        logic [63:0] n_cycle, n_instret;
        logic [5:0] ex;
        int code;
        int ex_code [6];
        int prio [3+NL];
        ex_code = '{0, 2, 3, 11, 4, 6};
        prio[0] = 11; prio[1] = 3; prio[2] = 7;
        for (int k = 0; k < NL; k++) prio[3+k] = 16 + k;
        old_st = m_mstatus;
        flush = m_go | m_ret;
        valid = i_ce && !flush;
        pend = m_mip & m_mie;
        code = -1;
        if (valid && m_mstatus[3])
            for (int j = 0; j < 3 + NL; j++) if (code < 0 && pend[prio[j]]) code = prio[j];
        take_int = (code >= 0);
        ex = {i_is_store_addr_misaligned, i_is_load_addr_misaligned, i_is_ecall,
              i_is_ebreak, i_is_inst_illegal, i_is_inst_addr_misaligned};
        take_exc = 0;
        if (valid && !take_int)
            for (int j = 0; j < 6; j++) if (!take_exc && ex[j]) begin take_exc = 1; code = ex_code[j]; end
        take = take_int || take_exc;
        tval = 0;
        if (take_exc) tval = (code == 3) ? i_pc : (code == 0 || code == 4 || code == 6) ? i_y : 32'h0;
        src = i_funct3[2] ? (i_imm & 32'h1F) : i_rs1;
        old = mread(i_csr_index);
        we = 0; nv = 0;
        case (i_funct3[1:0])
            2'b01: begin nv = src; we = 1; end
            2'b10: begin nv = old | src; we = (src != 0); end
            2'b11: begin nv = old & ~src; we = (src != 0); end
            default: ;
        endcase
        n_cycle = m_cycle + 64'd1;
        n_instret = m_instret + ((i_ce && !take && !flush) ? 64'd1 : 64'd0);
        if (i_ce && i_csr_en && !take && !flush && we) begin
            case (i_csr_index)
                12'h300: m_mstatus = (nv & 32'h88) | 32'h1800;
                12'h304: m_mie = nv & MASK;
                12'h305: m_mtvec = {nv[31:2], (nv[1:0] >= 2'd2) ? m_mtvec[1:0] : nv[1:0]};
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: n_cycle = {m_cycle[63:32], nv};
                12'hB80: n_cycle = {nv, m_cycle[31:0]};
                12'hB02: n_instret = {m_instret[63:32], nv};
                12'hB82: n_instret = {nv, m_instret[31:0]};
                default: ;
            endcase
        end
        m_cycle = n_cycle;
        m_instret = n_instret;
        m_mip = (32'(i_external_interrupt) << 11) | (32'(i_software_interrupt) << 3)
              | (32'(i_timer_interrupt) << 7) | (32'(i_local_interrupt) << 16);
        if (take) begin
            m_mepc = i_pc & ~32'h3;
            m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
            m_mcause = {take_int, 26'b0, 5'(code)};
            m_mtval = tval;
        end else if (valid && i_is_mret) begin
            m_mstatus = 32'h1880 | (old_st[7] ? 32'h8 : 32'h0);
        end
        m_go = take;
        m_ret = valid && i_is_mret && !take;
    endtask

    always @(negedge i_clk) begin
        if (run && i_rst_n) begin
            chk("csr_out", o_csr_out, mread(i_csr_index));
            chk("trap_addr", o_trap_address, mtrap_addr());
            chk("ret_addr", o_return_address, m_mepc);
            chk("go_pulse", {31'b0, o_go_to_trap_q}, {31'b0, m_go});
            chk("ret_pulse", {31'b0, o_return_from_trap_q}, {31'b0, m_ret});
        end
    end

    task automatic idle();
        i_ce = 0; i_csr_en = 0; i_funct3 = 0; i_rs1 = 0; i_imm = 0;
        i_is_inst_illegal = 0; i_is_ecall = 0; i_is_ebreak = 0; i_is_mret = 0;
        i_is_inst_addr_misaligned = 0; i_is_load_addr_misaligned = 0; i_is_store_addr_misaligned = 0;
    endtask

    task automatic cyc();
        @(posedge i_clk);
        if (i_rst_n) model_step();
        #1;
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] idx, input logic [31:0] v);
        idle();
        i_ce = 1; i_csr_en = 1; i_funct3 = f3; i_csr_index = idx;
        if (f3[2]) i_imm = v; else i_rs1 = v;
        cyc();
        idle();
    endtask

    task automatic peek(input string name, input logic [11:0] idx, input logic [31:0] exp);
        i_csr_index = idx;
        #1;
        chk(name, o_csr_out, exp);
    endtask

    logic [11:0] idx_tab [15] = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h301, 12'hF14};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        #11 i_rst_n = 1;
        run = 1;
        #1;
        chk("rst_go", {31'b0, o_go_to_trap_q}, 32'h0);
        chk("rst_ret", {31'b0, o_return_from_trap_q}, 32'h0);
        chk("rst_ret_addr", o_return_address, 32'h0);
        peek("rst_mstatus", 12'h300, 32'h0000_1800);
        peek("rst_mtvec", 12'h305, 32'h0000_0200);
        cyc();
        i_ce = 1; i_is_inst_illegal = 1; i_pc = 32'h1000;
        cyc();
        i_is_inst_illegal = 0; i_is_ecall = 1;
        chk("ill_go", {31'b0, o_go_to_trap_q}, 32'h1);
        chk("ill_mepc", o_return_address, 32'h1000);
        chk("ill_taddr", o_trap_address, 32'h200);
        peek("ill_mcause", 12'h342, 32'h2);
        peek("ill_mtval", 12'h343, 32'h0);
        peek("ill_mstatus", 12'h300, 32'h1800);
        cyc();
        idle();
        chk("flush_go", {31'b0, o_go_to_trap_q}, 32'h0);
        peek("flush_mcause", 12'h342, 32'h2);
        csr_op(3'b010, 12'h304, 32'h888);
        peek("mie_rs", 12'h304, 32'h888);
        csr_op(3'b011, 12'h304, 32'h8);
        peek("mie_rc", 12'h304, 32'h880);
        i_ce = 1; i_csr_en = 1; i_funct3 = 3'b010; i_csr_index = 12'h304; i_rs1 = 0;
        #1 chk("mie_rs0_out", o_csr_out, 32'h880);
        cyc();
        idle();
        peek("mie_rs0", 12'h304, 32'h880);
        csr_op(3'b001, 12'h344, 32'hFFFF_FFFF);
        peek("mip_ro", 12'h344, 32'h0);
        csr_op(3'b001, 12'h7C0, 32'h1234);
        peek("unimpl", 12'h7C0, 32'h0);
        csr_op(3'b001, 12'h305, 32'h101);
        peek("mtvec_wr", 12'h305, 32'h101);
        csr_op(3'b001, 12'h305, 32'h302);
        peek("mtvec_warl", 12'h305, 32'h301);
        csr_op(3'b001, 12'h305, 32'h101);
        csr_op(3'b110, 12'h300, 32'h8);
        peek("mstatus_mie", 12'h300, 32'h1808);
        i_external_interrupt = 1; i_timer_interrupt = 1;
        cyc();
        chk("irq_no_ce", {31'b0, o_go_to_trap_q}, 32'h0);
        peek("mip_smp", 12'h344, 32'h880);
        i_ce = 1; i_pc = 32'h2000;
        cyc();
        idle();
        i_external_interrupt = 0; i_timer_interrupt = 0;
        chk("vec_go", {31'b0, o_go_to_trap_q}, 32'h1);
        chk("vec_taddr", o_trap_address, 32'h12C);
        peek("vec_mcause", 12'h342, 32'h8000_000B);
        peek("vec_mstatus", 12'h300, 32'h1880);
        cyc();
        i_ce = 1; i_is_mret = 1;
        cyc();
        idle();
        chk("mret_pulse", {31'b0, o_return_from_trap_q}, 32'h1);
        chk("mret_addr", o_return_address, 32'h2000);
        peek("mret_mstatus", 12'h300, 32'h1888);
        cyc();
        csr_op(3'b010, 12'h304, 32'h000C_0000);
        peek("mie_local", 12'h304, 32'h000C_0880);
        i_local_interrupt = 4'b1100;
        cyc();
        i_ce = 1; i_pc = 32'h3000;
        cyc();
        idle();
        i_local_interrupt = 0;
        chk("loc_go", {31'b0, o_go_to_trap_q}, 32'h1);
        chk("loc_taddr", o_trap_address, 32'h148);
        peek("loc_mcause", 12'h342, 32'h8000_0012);
        cyc();
        i_ce = 1; i_is_mret = 1;
        cyc();
        idle();
        cyc();
        csr_op(3'b001, 12'hB80, 32'hFFFF_FFFF);
        csr_op(3'b001, 12'hB00, 32'hFFFF_FFFE);
        cyc();
        cyc();
        peek("wrap_lo", 12'hB00, 32'h0);
        peek("wrap_hi", 12'hB80, 32'h0);
        csr_op(3'b001, 12'hB02, 32'h5);
        csr_op(3'b001, 12'hB82, 32'h0);
        i_ce = 1; i_is_ecall = 1; i_pc = 32'h4000;
        cyc();
        i_is_ecall = 0;
        chk("ecall_go", {31'b0, o_go_to_trap_q}, 32'h1);
        peek("ecall_instret", 12'hB02, 32'h5);
        peek("ecall_mcause", 12'h342, 32'hB);
        cyc();
        cyc();
        idle();
        peek("instret_inc", 12'hB02, 32'h6);
        for (int n = 0; n < 4000; n++) begin
            i_ce = ($urandom_range(3) != 0);
            i_is_inst_illegal = ($urandom_range(19) == 0);
            i_is_ecall = ($urandom_range(19) == 0);
            i_is_ebreak = ($urandom_range(19) == 0);
            i_is_mret = ($urandom_range(11) == 0);
            i_is_inst_addr_misaligned = ($urandom_range(29) == 0);
            i_is_load_addr_misaligned = ($urandom_range(23) == 0);
            i_is_store_addr_misaligned = ($urandom_range(23) == 0);
            i_csr_en = ($urandom_range(2) == 0);
            i_funct3 = 3'($urandom_range(7));
            i_csr_index = idx_tab[$urandom_range(14)];
            case ($urandom_range(3))
                0: i_rs1 = 32'h0;
                1: i_rs1 = $urandom & 32'h000F_0888;
                2: i_rs1 = 32'h8;
                default: i_rs1 = $urandom;
            endcase
            i_imm = $urandom;
            i_pc = $urandom & ~32'h3;
            i_y = $urandom;
            if ($urandom_range(7) == 0) i_external_interrupt = ~i_external_interrupt;
            if ($urandom_range(7) == 0) i_software_interrupt = ~i_software_interrupt;
            if ($urandom_range(7) == 0) i_timer_interrupt = ~i_timer_interrupt;
            if ($urandom_range(7) == 0) i_local_interrupt = NL'($urandom);
            cyc();
        end
        idle();
        cyc();
        cyc();
        i_ce = 1; i_is_inst_illegal = 1;
        cyc();
        idle();
        chk("pre_rst_go", {31'b0, o_go_to_trap_q}, 32'h1);
        #2 i_rst_n = 0;
        #1;
        chk("rst_mid_go", {31'b0, o_go_to_trap_q}, 32'h0);
        chk("rst_mid_ret_addr", o_return_address, 32'h0);
        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csr_ssm_irq.md
# csr_ssm_irq

Parametrised machine-mode CSR and trap controller, the successor to the current CSR state machine. It adds a timer interrupt, NUM_LOCAL_IRQ platform-local interrupt lines, fixed-priority arbitration, vectored mtvec mode, full misaligned-exception reporting, and 64-bit mcycle/minstret counters. It sits beside the writeback stage: it commits CSR instructions and trap/return events, and it hands the PC mux the trap and return addresses.

## Interface
- TRAP_ADDRESS, 32'h0000_0000: reset value of mtvec; bits [1:0] are ignored and mode resets to 0.
- NUM_LOCAL_IRQ, 4: local interrupt count, legal range 1..16. These map to mip/mie bits 16+k.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_external_interrupt, i_software_interrupt, i_timer_interrupt  in  1 each  level-sensitive MEI/MSI/MTI.
- i_local_interrupt  in  NUM_LOCAL_IRQ  level-sensitive local interrupts.
- i_ce  in  1  writeback stage holds a valid instruction this cycle.
- i_is_inst_illegal, i_is_ecall, i_is_ebreak, i_is_mret  in  1 each  decoded events.
- i_is_inst_addr_misaligned, i_is_load_addr_misaligned, i_is_store_addr_misaligned  in  1 each.
- i_csr_en  in  1  instruction is SYSTEM CSR-type.
- i_funct3  in  3  CSR op. 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- i_csr_index  in  12  CSR address.
- i_rs1  in  32  register operand.
- i_imm  in  32  zimm in bits [4:0].
- i_pc  in  32  PC of the writeback instruction.
- i_y  in  32  faulting data/branch address.
- o_csr_out  out  32  combinational read of i_csr_index (old value).
- o_trap_address  out  32  combinational trap vector.
- o_return_address  out  32  mepc.
- o_go_to_trap_q  out  1  registered one-cycle trap-entry pulse.
- o_return_from_trap_q  out  1  registered one-cycle MRET pulse.

## Operation
- **Implemented CSRs.**
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] hardwired 11.
  - mie 0x304.
  - mip 0x344, read-only.
  - mtvec 0x305.
  - mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - Unimplemented indices read 0 and ignore writes.
- **Writable interrupt bits.** Only MSIE[3], MTIE[7], MEIE[11] and bits 16..16+NUM_LOCAL_IRQ-1 are writable; all other bits read 0. mip reflects the same bit positions.
- **mip sampling.** mip is registered from the interrupt inputs every cycle; software writes to mip are ignored.
- **mtvec.** mode is WARL: writes of 2 or 3 keep the old mode. mepc[1:0] is forced to 0.
- **CSR write data.**
  - RW: src. RS: old|src. RC: old&~src.
  - src is i_rs1 for 001–011 and zero-extended i_imm[4:0] for 101–111.
  - RS/RC with src==0 perform no write.
- **CSR commit condition.** The CSR write commits when i_ce & i_csr_en & ~take_trap & ~flush.
- **Interrupt take.** An interrupt is taken when mstatus.MIE & |(mip&mie) & i_ce & ~flush.
- **Priority.** Interrupts take priority over exceptions.
  - Interrupts: MEI(11) > MSI(3) > MTI(7) > local, lowest index first (cause 16+k).
  - Exceptions: inst-misaligned(0) > illegal(2) > ebreak(3) > ecall(11) > load-misaligned(4) > store-misaligned(6).
- **Trap entry** (take_trap):
  - mepc←i_pc, MPIE←MIE, MIE←0.
  - mcause←{intbit, 26'b0, code[4:0]}.
  - mtval←i_y for misaligned, i_pc for ebreak, 0 otherwise.
  - o_go_to_trap_q←1.
- **MRET** (i_ce & i_is_mret & ~take_trap & ~flush): MIE←MPIE, MPIE←1, o_return_from_trap_q←1.
- **o_trap_address.** {mtvec.base,2'b00}, plus 4*mcause.code when mode==1 and mcause.intbit==1.
- **flush.** flush = o_go_to_trap_q | o_return_from_trap_q. Events arriving in a flush cycle are ignored.
- **Counters.**
  - mcycle increments every cycle.
  - minstret increments on i_ce & ~take_trap & ~flush.
  - Both wrap from 2^64-1 to 0.
  - A CSR write to either half overrides that cycle's increment for the whole counter; the other half holds.

## Timing
- **Reset values.** Every register and output clears asynchronously on reset:
  - mstatus = 0x0000_1800, mtvec = {TRAP_ADDRESS[31:2],2'b00}.
  - mie, mip, mscratch, mepc, mcause, mtval, counters = 0.
  - o_go_to_trap_q = o_return_from_trap_q = 0, so o_return_address = 0.
- **Latency.** Events are sampled at edge N. CSR state and the pulses are visible after edge N. o_trap_address is valid in the same cycle as o_go_to_trap_q.
- **Interrupt input latency.** One cycle of mip registration: an input asserted before edge N can be taken at edge N+1 at the earliest.
- **Pulse width.** Pulses last exactly one cycle; back-to-back pulses are impossible because of the flush rule.
- **CSR write vs trap.** A CSR write of mstatus/mie in cycle N affects interrupt-take from edge N+1.
- **Reset mid-trap.** A reset asserted mid-pulse drops the pulse immediately.

## Test plan
- **Reset defaults.** Release reset -> mtvec reads TRAP_ADDRESS, mstatus reads 0x1800, both pulses 0.
- **Illegal instruction.** i_is_inst_illegal with i_pc=0x1000 -> next cycle o_go_to_trap_q=1, mcause=0x2, mepc=0x1000, MIE=0, mtval=0.
- **CSRRS/CSRRC on mie.** CSRRS mie, rs1=0x888 -> mie=0x888; CSRRC rs1=0x8 -> 0x880; CSRRS rs1=0 -> unchanged, o_csr_out=0x880.
- **Vectored interrupt.** mtvec=0x101 (CSRRW), MIE=1, mie=0x880, assert external and timer together -> MEI taken, mcause=0x8000_000B, o_trap_address=0x12C. MRET -> MIE=1, o_return_address=mepc.
- **Local interrupt.** NUM_LOCAL_IRQ=4, i_local_interrupt=4'b1100 enabled -> mcause=0x8000_0012 (cause 18).
- **Counter wrap.** Write mcycleh=0xFFFF_FFFF, then mcycle=0xFFFF_FFFE -> two cycles later reads 0/0. minstret does not increment on a trapping cycle.
